// File: rtl/tree_classifier.sv
// ---------------------------------------------------------------------------
// tree_classifier
//
// Decision-tree inference stage. One sample is accepted per
// data_ready/data_processed handshake. The stage then walks a complete binary
// tree of programmable thresholds, one level per clock. The leaf's class label
// is presented on a valid/ready output port.
//
// Ports:
//   clk            in   single clock, rising-edge
//   reset          in   synchronous, active-high reset
//   data_in        in   sample from the upstream input buffer
//   data_ready     in   sample valid, held by upstream until acknowledged
//   data_processed out  one-cycle acknowledge of a captured sample
//   class_out      out  leaf label of the last classified sample
//   class_valid    out  result valid, held until class_ready
//   class_ready    in   downstream accept
//   busy           out  high whenever the FSM is not idle
//   cfg_we         in   configuration write strobe
//   cfg_addr       in   threshold address (0..2^DEPTH-2), leaf address
//                       (2^DEPTH-1..2^(DEPTH+1)-2); all-ones is ignored
//   cfg_data       in   threshold value, or leaf label in its low bits
// ---------------------------------------------------------------------------
module tree_classifier #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 3,
  parameter int CLASS_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_ready,
  output logic                   data_processed,
  output logic [CLASS_WIDTH-1:0] class_out,
  output logic                   class_valid,
  input  logic                   class_ready,
  output logic                   busy,
  input  logic                   cfg_we,
  input  logic [DEPTH:0]         cfg_addr,
  input  logic [DATA_WIDTH-1:0]  cfg_data
);

  localparam int NUM_NODES  = 2**DEPTH - 1;
  localparam int NUM_LEAVES = 2**DEPTH;
  localparam int AW         = DEPTH + 1;
  localparam int LW         = $clog2(DEPTH + 1);

  localparam logic [AW-1:0]         LEAF_BASE  = AW'(NUM_NODES);
  localparam logic [AW-1:0]         CFG_IGNORE = {AW{1'b1}};
  localparam logic [LW-1:0]         LAST_LEVEL = LW'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] THR_RESET  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [DATA_WIDTH-1:0]  r_thr  [NUM_NODES];
  logic [CLASS_WIDTH-1:0] r_leaf [NUM_LEAVES];

  logic [1:0]             r_state;
  logic [DATA_WIDTH-1:0]  r_sample;
  logic [AW-1:0]          r_node;
  logic [LW-1:0]          r_level;
  logic                   r_dataProcessed;
  logic [CLASS_WIDTH-1:0] r_classOut;
  logic                   r_classValid;

  logic                   w_goRight;
  logic [AW-1:0]          w_child;

  // Threshold/leaf tables. Nonblocking writes mean a node compared in the
  // same cycle it is written still sees its old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        r_thr[i] <= THR_RESET;
      end
      for (int i = 0; i < NUM_LEAVES; i++) begin
        r_leaf[i] <= CLASS_WIDTH'(i);
      end
    end else if (cfg_we) begin
      if (cfg_addr < LEAF_BASE) begin
        r_thr[DEPTH'(cfg_addr)] <= cfg_data;
      end else if (cfg_addr != CFG_IGNORE) begin
        r_leaf[DEPTH'(cfg_addr - LEAF_BASE)] <= cfg_data[CLASS_WIDTH-1:0];
      end
    end
  end

  // Heap-indexed step: children of n are 2n+1 (left) and 2n+2 (right).
  // Equality goes right.
  assign w_goRight = (r_sample >= r_thr[DEPTH'(r_node)]);
  assign w_child   = (r_node << 1) + AW'(1) + AW'(w_goRight);

  // Control FSM. The acknowledge is a single-cycle pulse, so it defaults low
  // and is only raised on the capture edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_sample        <= '0;
      r_node          <= '0;
      r_level         <= '0;
      r_dataProcessed <= 1'b0;
      r_classOut      <= '0;
      r_classValid    <= 1'b0;
    end else begin
      r_dataProcessed <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (data_ready) begin
            r_sample        <= data_in;
            r_node          <= '0;
            r_level         <= '0;
            r_dataProcessed <= 1'b1;
            r_state         <= S_WALK;
          end
        end
        S_WALK: begin
          r_node  <= w_child;
          r_level <= r_level + LW'(1);
          // The child reached from the last internal level is a leaf node.
          if (r_level == LAST_LEVEL) begin
            r_classOut   <= r_leaf[DEPTH'(w_child - LEAF_BASE)];
            r_classValid <= 1'b1;
            r_state      <= S_OUT;
          end
        end
        S_OUT: begin
          // Returning to IDLE first guarantees a capture never shares the
          // edge on which the result is accepted.
          if (class_ready) begin
            r_classValid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_processed = r_dataProcessed;
  assign class_out      = r_classOut;
  assign class_valid    = r_classValid;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_tree_classifier.sv
// ---------------------------------------------------------------------------
// tb_tree_classifier
//
// Directed, self-checking bench for tree_classifier at its default
// parameters (8-bit samples, depth 3, 2-bit labels). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_tree_classifier;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_ready;
  logic       data_processed;
  logic [1:0] class_out;
  logic       class_valid;
  logic       class_ready;
  logic       busy;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;

  int compared   = 0;
  int mismatched = 0;

  tree_classifier #(
    .DATA_WIDTH (8),
    .DEPTH      (3),
    .CLASS_WIDTH(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_ready    (data_ready),
    .data_processed(data_processed),
    .class_out     (class_out),
    .class_valid   (class_valid),
    .class_ready   (class_ready),
    .busy          (busy),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cfgWrite(input logic [3:0] addr, input logic [7:0] value);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = value;
    tick();
    cfg_we   = 1'b0;
  endtask

  // One complete sample with downstream always ready: capture, three walk
  // edges, then acceptance one edge after class_valid rises.
  task automatic applyStimulus(input logic [7:0] sample,
                               input logic [1:0] expClass, input string tag);
    data_in     = sample;
    data_ready  = 1'b1;
    class_ready = 1'b1;
    tick();
    checkOutput({tag, "_ack"}, 8'(data_processed), 8'd1);
    checkOutput({tag, "_busy"}, 8'(busy), 8'd1);
    data_ready = 1'b0;
    tick();
    checkOutput({tag, "_ack_drop"}, 8'(data_processed), 8'd0);
    tick();
    checkOutput({tag, "_early_valid"}, 8'(class_valid), 8'd0);
    tick();
    checkOutput({tag, "_valid"}, 8'(class_valid), 8'd1);
    checkOutput({tag, "_class"}, 8'(class_out), 8'(expClass));
    tick();
    checkOutput({tag, "_accepted"}, 8'(class_valid), 8'd0);
    checkOutput({tag, "_idle"}, 8'(busy), 8'd0);
  endtask

  initial begin
    reset       = 1'b1;
    data_in     = 8'h00;
    data_ready  = 1'b0;
    class_ready = 1'b1;
    cfg_we      = 1'b0;
    cfg_addr    = 4'd0;
    cfg_data    = 8'h00;
    tick();
    tick();
    checkOutput("rst_ack", 8'(data_processed), 8'd0);
    checkOutput("rst_class", 8'(class_out), 8'd0);
    checkOutput("rst_valid", 8'(class_valid), 8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    reset = 1'b0;
    tick();

    // Default tree: all thresholds 0x80, leaf[i] = i mod 4.
    applyStimulus(8'h00, 2'd0, "def_00");
    applyStimulus(8'hFF, 2'd3, "def_ff");

    // Back-to-back samples with data_ready held: 5-cycle period, one-cycle
    // acknowledge, single idle cycle between samples.
    data_in    = 8'h00;
    data_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      checkOutput($sformatf("hs_ack_%0d", c), 8'(data_processed),
                  (c % 5 == 0) ? 8'd1 : 8'd0);
      checkOutput($sformatf("hs_busy_%0d", c), 8'(busy),
                  (c % 5 == 4) ? 8'd0 : 8'd1);
      if (c == 14) data_ready = 1'b0;
    end

    // Programmed tree: thr[0]=0x40, thr[2]=0x60, leaf[4]=2.
    cfgWrite(4'd0, 8'h40);
    cfgWrite(4'd2, 8'h60);
    cfgWrite(4'd11, 8'h02);
    applyStimulus(8'h50, 2'd2, "prog_50");
    applyStimulus(8'h40, 2'd2, "prog_40_eq");
    applyStimulus(8'h3F, 2'd0, "prog_3f");

    // Backpressure: 0xFF walks 0->2->6->14 (leaf 7 = 3). The next sample is
    // already pending and must not be acknowledged while the result waits.
    class_ready = 1'b0;
    data_in     = 8'hFF;
    data_ready  = 1'b1;
    tick();
    checkOutput("bp_ack", 8'(data_processed), 8'd1);
    data_in = 8'h00;
    tick();
    tick();
    tick();
    checkOutput("bp_valid", 8'(class_valid), 8'd1);
    checkOutput("bp_class", 8'(class_out), 8'd3);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput($sformatf("bp_hold_valid_%0d", c), 8'(class_valid), 8'd1);
      checkOutput($sformatf("bp_hold_class_%0d", c), 8'(class_out), 8'd3);
      checkOutput($sformatf("bp_hold_ack_%0d", c), 8'(data_processed), 8'd0);
    end
    class_ready = 1'b1;
    tick();
    checkOutput("bp_release_valid", 8'(class_valid), 8'd0);
    checkOutput("bp_release_ack", 8'(data_processed), 8'd0);
    tick();
    checkOutput("bp_next_ack", 8'(data_processed), 8'd1);
    data_ready = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("bp_next_valid", 8'(class_valid), 8'd1);
    checkOutput("bp_next_class", 8'(class_out), 8'd0);
    tick();

    // All-ones address must not alias onto leaf 0.
    cfgWrite(4'd15, 8'hFF);
    applyStimulus(8'h00, 2'd0, "addr15");

    // Root threshold rewritten on the root-compare edge: 0x50 must still go
    // right against the old 0x40 and end at leaf 4 (= 2).
    data_in    = 8'h50;
    data_ready = 1'b1;
    tick();
    checkOutput("race_ack", 8'(data_processed), 8'd1);
    data_ready = 1'b0;
    cfg_we     = 1'b1;
    cfg_addr   = 4'd0;
    cfg_data   = 8'hF0;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
    checkOutput("race_valid", 8'(class_valid), 8'd1);
    checkOutput("race_class", 8'(class_out), 8'd2);
    tick();
    applyStimulus(8'h50, 2'd0, "race_newthr");

    // Reset mid-walk with data_ready still high. leaf[7] is cleared first so
    // the recaptured 0xFF only yields 3 if the tables were reset.
    cfgWrite(4'd14, 8'h00);
    data_in    = 8'hFF;
    data_ready = 1'b1;
    tick();
    checkOutput("abort_ack", 8'(data_processed), 8'd1);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("abort_rst_valid", 8'(class_valid), 8'd0);
    checkOutput("abort_rst_busy", 8'(busy), 8'd0);
    checkOutput("abort_rst_ack", 8'(data_processed), 8'd0);
    checkOutput("abort_rst_class", 8'(class_out), 8'd0);
    reset = 1'b0;
    tick();
    checkOutput("abort_recap_ack", 8'(data_processed), 8'd1);
    checkOutput("abort_recap_valid", 8'(class_valid), 8'd0);
    data_ready = 1'b0;
    tick();
    checkOutput("abort_walk1_valid", 8'(class_valid), 8'd0);
    tick();
    checkOutput("abort_walk2_valid", 8'(class_valid), 8'd0);
    tick();
    checkOutput("abort_done_valid", 8'(class_valid), 8'd1);
    checkOutput("abort_done_class", 8'(class_out), 8'd3);
    tick();
    checkOutput("abort_accepted", 8'(class_valid), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tree_classifier.md
# tree_classifier

Decision-tree inference stage directly downstream of the double-buffered sensor input buffer. It accepts one DATA_WIDTH sample per `data_ready`/`data_processed` handshake and walks a complete binary tree of programmable thresholds, one level per clock. It then presents the leaf's class label on a valid/ready output port. Thresholds and leaf labels are loaded through a simple register-write port.

## Interface
- `DATA_WIDTH`, 8: sample and threshold width.
- `DEPTH`, 3: tree depth, legal range 1..6; there are 2^DEPTH−1 internal nodes and 2^DEPTH leaves.
- `CLASS_WIDTH`, 2: class label width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  sample from the input buffer.
- `data_ready`  in  1  sample valid; held high by the upstream block until it sees `data_processed`.
- `data_processed`  out  1  one-cycle acknowledge to the upstream block.
- `class_out`  out  CLASS_WIDTH  result label.
- `class_valid`  out  1  result valid; held until accepted.
- `class_ready`  in  1  downstream accept.
- `busy`  out  1  high in every state except IDLE.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_addr`  in  DEPTH+1  configuration address.
- `cfg_data`  in  DATA_WIDTH  configuration data.

## Operation
- Storage:
  - `thr[0..2^DEPTH−2]` holds the node thresholds.
  - `leaf[0..2^DEPTH−1]` holds the leaf labels.
  - Reset values: every `thr` = 2^(DATA_WIDTH−1) (0x80); `leaf[i]` = i mod 2^CLASS_WIDTH.
- Config decode:
  - `cfg_addr` < 2^DEPTH−1: write `thr[cfg_addr]`.
  - 2^DEPTH−1 ≤ `cfg_addr` ≤ 2^(DEPTH+1)−2: write `leaf[cfg_addr−(2^DEPTH−1)]` from `cfg_data[CLASS_WIDTH−1:0]`.
  - All-ones address: ignored.
  - Writes are accepted in any state. A node read in the same cycle as a write to it sees the old value.
- Tree walk (heap indexing):
  - The walk starts at node 0. From node n, the left child is 2n+1 and the right child is 2n+2.
  - Go right iff `sample` ≥ `thr[n]`, compared as an unsigned comparison.
  - Final leaf index = node − (2^DEPTH−1).
- FSM states: IDLE, WALK, OUT.
  - IDLE: if `data_ready` = 1 at an edge, latch `data_in` into `sample`, set node = 0 and level = 0, set `data_processed` = 1 for exactly one cycle, and go to WALK. Otherwise stay in IDLE.
  - WALK: each edge advances node one level and increments level.
    - On the edge where level reaches DEPTH, register `class_out` ← `leaf[final index]`, set `class_valid` = 1, and go to OUT.
    - `data_ready` is ignored in this state.
  - OUT: hold `class_out` and `class_valid`. At the first edge with `class_ready` = 1, clear `class_valid` and go to IDLE. `data_ready` is ignored in this state.
- Reset values of outputs: `data_processed` = 0, `class_out` = 0, `class_valid` = 0, `busy` = 0. The FSM returns to IDLE and the tables return to their reset contents.
- Reset asserted mid-walk or mid-OUT aborts the sample with no output. If the upstream block still holds `data_ready`, that sample is captured again after reset deasserts.

## Timing
- `data_ready` sampled high in IDLE at edge k:
  - `data_processed` is high from edge k to edge k+1. The upstream block drops `data_ready` at edge k+1.
  - `busy` is high from edge k.
  - WALK occupies edges k+1 through k+DEPTH.
  - `class_valid` rises at edge k+DEPTH, so latency is DEPTH cycles (3 by default).
- `class_ready` already high when `class_valid` rises: the result is accepted at edge k+DEPTH+1, and the next capture occurs no earlier than edge k+DEPTH+2.
  - Minimum period is DEPTH+2 cycles per sample.
- The FSM never captures in the same edge in which OUT is left.
- `data_processed` is never asserted outside the capture edge; there is exactly one pulse per sample.
- Backpressure: `class_ready` low holds OUT indefinitely with `class_out` stable. No new sample is acknowledged during that time, so the upstream block keeps `data_ready` high.

## Test plan
- Reset defaults, `class_ready` = 1:
  - `data_in` = 0x00 → `class_valid` 3 cycles after capture with `class_out` = 0 (leaf 0).
  - `data_in` = 0xFF → `class_out` = 3 (leaf 7).
- Handshake: hold `data_ready` = 1 continuously → `data_processed` pulses exactly once per sample, one cycle wide, spaced 5 cycles apart; `busy` low for exactly 1 cycle between samples.
- Programmed tree:
  - Write `thr[0]` = 0x40, `thr[2]` = 0x60, and `cfg_addr` = 11 (leaf 4) = 2.
  - `data_in` = 0x50 → path 0→2→5→11 → `class_out` = 2.
  - `data_in` = 0x40 (equality goes right) → path 0→2→5→11 → `class_out` = 2.
  - `data_in` = 0x3F → path 0→1→3→7 → `class_out` = 0.
- Backpressure: `class_ready` = 0 for 10 cycles after `class_valid` → `class_valid` and `class_out` stable, no `data_processed` pulse. Raise `class_ready` → `class_valid` drops the next edge and capture follows one edge later.
- Boundaries:
  - Write to `cfg_addr` = 15 changes nothing.
  - Write `thr[0]` in the same cycle as the root compare → result uses the old threshold.
- Reset at level 1 mid-walk with `data_ready` still high → `class_valid` is never asserted for the aborted sample. The sample is recaptured on the first edge after reset and completes normally.
